// File: rtl/axi_lite_cmd_arbiter_if.sv
// Requester-side and master-side command signals of the AXI-Lite command arbiter.
// The slave modport belongs to the arbiter; the master modport drives it from outside.
interface axi_lite_cmd_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [NUM_REQ-1:0]            i_req_en;
  logic [NUM_REQ-1:0]            i_req_wr_rd;
  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr;
  logic [NUM_REQ*4-1:0]          i_req_byte_en;
  logic [NUM_REQ*32-1:0]         i_req_data;
  logic [NUM_REQ-1:0]            o_req_ack;
  logic [NUM_REQ-1:0]            o_req_error;
  logic [31:0]                   o_req_data;
  logic [NUM_REQ-1:0]            o_grant;
  logic                          o_cmd_en;
  logic                          o_cmd_wr_rd;
  logic [ADDR_WIDTH-1:0]         o_cmd_addr;
  logic [3:0]                    o_cmd_byte_en;
  logic [31:0]                   o_cmd_data_count;
  logic [31:0]                   o_cmd_data;
  logic                          i_cmd_ack;
  logic                          i_cmd_error;
  logic [31:0]                   i_cmd_data;

  modport slave (
    input  i_req_en, i_req_wr_rd, i_req_addr, i_req_byte_en, i_req_data,
    input  i_cmd_ack, i_cmd_error, i_cmd_data,
    output o_req_ack, o_req_error, o_req_data, o_grant,
    output o_cmd_en, o_cmd_wr_rd, o_cmd_addr, o_cmd_byte_en, o_cmd_data_count, o_cmd_data
  );

  modport master (
    output i_req_en, i_req_wr_rd, i_req_addr, i_req_byte_en, i_req_data,
    output i_cmd_ack, i_cmd_error, i_cmd_data,
    input  o_req_ack, o_req_error, o_req_data, o_grant,
    input  o_cmd_en, o_cmd_wr_rd, o_cmd_addr, o_cmd_byte_en, o_cmd_data_count, o_cmd_data
  );
endinterface

// File: rtl/axi_lite_cmd_arbiter.sv
// Grants one of NUM_REQ requesters the AXI-Lite master command port per four-phase handshake.
// Define AXI_CMD_ARB_FIXED_PRIORITY_EN for lowest-index-wins instead of round robin.
module axi_lite_cmd_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst,
  axi_lite_cmd_arbiter_if.slave bus
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] Lsb = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         ptr_q, ptr_d, gidx_q, gidx_d, win_idx;
  logic                    win_found;
  logic [NUM_REQ-1:0]      grant_q, grant_d, ack_q, ack_d, err_q, err_d;
  logic                    cmd_en_q, cmd_en_d, wr_rd_q, wr_rd_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             wdata_q, wdata_d, rdata_q, rdata_d;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef AXI_CMD_ARB_FIXED_PRIORITY_EN
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found && bus.i_req_en[i]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(i);
      end
    end
`else
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned k;
      k = 32'(ptr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!win_found && bus.i_req_en[k]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(k);
      end
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    ack_d    = ack_q;
    err_d    = err_q;
    cmd_en_d = cmd_en_q;
    wr_rd_d  = wr_rd_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d  = StIssue;
          gidx_d   = win_idx;
          grant_d  = Lsb << win_idx;
          cmd_en_d = 1'b1;
          wr_rd_d  = bus.i_req_wr_rd[win_idx];
          addr_d   = bus.i_req_addr[32'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          be_d     = bus.i_req_byte_en[32'(win_idx)*4 +: 4];
          wdata_d  = bus.i_req_data[32'(win_idx)*32 +: 32];
        end
      end
      StIssue: begin
        if (bus.i_cmd_ack) begin
          state_d  = StResp;
          rdata_d  = bus.i_cmd_data;
          ack_d    = Lsb << gidx_q;
          err_d    = bus.i_cmd_error ? (Lsb << gidx_q) : '0;
          cmd_en_d = 1'b0;
        end
      end
      StResp: begin
        // Both sides must have released their half of the handshake.
        if (!bus.i_cmd_ack && !bus.i_req_en[gidx_q]) begin
          state_d = StIdle;
          ack_d   = '0;
          err_d   = '0;
          grant_d = '0;
          ptr_d   = (gidx_q == IdxW'(NUM_REQ - 1)) ? '0 : gidx_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      cmd_en_q <= 1'b0;
      wr_rd_q  <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      cmd_en_q <= cmd_en_d;
      wr_rd_q  <= wr_rd_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.o_grant          = grant_q;
  assign bus.o_req_ack        = ack_q;
  assign bus.o_req_error      = err_q;
  assign bus.o_req_data       = rdata_q;
  assign bus.o_cmd_en         = cmd_en_q;
  assign bus.o_cmd_wr_rd      = wr_rd_q;
  assign bus.o_cmd_addr       = addr_q;
  assign bus.o_cmd_byte_en    = be_q;
  assign bus.o_cmd_data       = wdata_q;
  assign bus.o_cmd_data_count = 32'd1;
endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Bench for axi_lite_cmd_arbiter: transaction-level model compared every cycle, plus
// directed scenarios with literal expectations. Honours AXI_CMD_ARB_FIXED_PRIORITY_EN.
module tb_axi_lite_cmd_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_cmd_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW)) bus ();
  axi_lite_cmd_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Requesters: raise en while issued > done, drop on ack, count completions.
  int issued[N] = '{default: 0};
  int done[N]   = '{default: 0};
  bit hold[N]   = '{default: 1'b0};
  logic [N-1:0] ack_prev = '0;
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < N; k++) begin
      if (bus.o_req_ack[k] && !ack_prev[k]) done[k]++;
      ack_prev[k] = bus.o_req_ack[k];
      bus.i_req_en[k] = !bus.o_req_ack[k] && !hold[k] && (issued[k] > done[k]);
    end
  end

  // Master: acks after ack_dly cycles of o_cmd_en, drops ack once o_cmd_en falls.
  int ack_dly = 1;
  bit resp_err = 1'b0;
  logic [31:0] resp_data = 32'hDEAD_BEEF;
  int cnt = 0;
  always @(posedge clk) begin
    #2;
    if (rst) begin
      bus.i_cmd_ack = 1'b0; bus.i_cmd_error = 1'b0; bus.i_cmd_data = '0; cnt = 0;
    end else if (bus.i_cmd_ack) begin
      if (!bus.o_cmd_en) bus.i_cmd_ack = 1'b0;
    end else if (bus.o_cmd_en) begin
      if (cnt >= ack_dly) begin
        bus.i_cmd_ack = 1'b1; bus.i_cmd_error = resp_err; bus.i_cmd_data = resp_data;
        resp_data = resp_data + 32'h0101_0101;
        cnt = 0;
      end else cnt++;
    end
  end

  // Transaction model: owner (-1 = none), outstanding command, delivered response.
  int          m_owner, m_ptr;
  bit          m_wait, m_acked, m_err;
  logic        m_wr;
  logic [AW-1:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata, m_rdata;
  always @(posedge clk or posedge rst) begin
    int w, idx;
    if (rst) begin
      m_owner <= -1; m_ptr <= 0; m_wait <= 0; m_acked <= 0; m_err <= 0;
      m_wr <= 0; m_addr <= '0; m_be <= '0; m_wdata <= '0; m_rdata <= '0;
    end else if (m_owner < 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
`ifdef AXI_CMD_ARB_FIXED_PRIORITY_EN
        idx = k;
`else
        idx = (m_ptr + k) % N;
`endif
        if (w < 0 && bus.i_req_en[idx]) w = idx;
      end
      if (w >= 0) begin
        m_owner <= w; m_wait <= 1;
        m_wr <= bus.i_req_wr_rd[w];
        m_addr <= bus.i_req_addr[w*AW +: AW];
        m_be <= bus.i_req_byte_en[w*4 +: 4];
        m_wdata <= bus.i_req_data[w*32 +: 32];
      end
    end else if (m_wait) begin
      if (bus.i_cmd_ack) begin
        m_wait <= 0; m_acked <= 1; m_err <= bus.i_cmd_error; m_rdata <= bus.i_cmd_data;
      end
    end else if (!bus.i_cmd_ack && !bus.i_req_en[m_owner]) begin
      m_owner <= -1; m_acked <= 0; m_ptr <= (m_owner + 1) % N;
    end
  end

  int grant_log[$];
  logic [N-1:0] prev_grant = '0;
  always @(negedge clk) begin
    logic [N-1:0] one, eg, ea, ee;
    one = 1;
    eg = (m_owner >= 0) ? (one << m_owner) : '0;
    ea = m_acked ? eg : '0;
    ee = (m_acked && m_err) ? eg : '0;
    chk("m_grant", bus.o_grant, eg);
    chk("m_cmd_en", bus.o_cmd_en, m_wait);
    chk("m_ack", bus.o_req_ack, ea);
    chk("m_error", bus.o_req_error, ee);
    chk("m_data_count", bus.o_cmd_data_count, 32'd1);
    if (m_wait) begin
      chk("m_cmd_wr_rd", bus.o_cmd_wr_rd, m_wr);
      chk("m_cmd_addr", bus.o_cmd_addr, m_addr);
      chk("m_cmd_byte_en", bus.o_cmd_byte_en, m_be);
      chk("m_cmd_data", bus.o_cmd_data, m_wdata);
    end
    if (m_acked) chk("m_req_data", bus.o_req_data, m_rdata);
    if (bus.o_grant != '0 && prev_grant == '0) grant_log.push_back($clog2(bus.o_grant));
    prev_grant = bus.o_grant;
  end

  task automatic set_req(input int k, input bit wr, input logic [AW-1:0] a,
                         input logic [3:0] be, input logic [31:0] d);
    bus.i_req_wr_rd[k] = wr;
    bus.i_req_addr[k*AW +: AW] = a;
    bus.i_req_byte_en[k*4 +: 4] = be;
    bus.i_req_data[k*32 +: 32] = d;
  endtask

  task automatic wait_ack(input string name, input int bound);
    bit hit = 0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk);
      hit = (bus.o_req_ack != '0);
    end
    chk(name, hit, 1'b1);
  endtask

  task automatic wait_idle(input string name, input int bound);
    bit hit = 0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk);
      hit = (bus.o_grant == '0) && (bus.o_cmd_en == 1'b0) && (bus.i_req_en == '0);
    end
    chk(name, hit, 1'b1);
  endtask

  initial begin
    int base;
    bit hit;
    bus.i_req_wr_rd = '0; bus.i_req_addr = '0; bus.i_req_byte_en = '0; bus.i_req_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", bus.o_grant, 0);
    chk("rst_cmd_en", bus.o_cmd_en, 0);
    chk("rst_ack", bus.o_req_ack, 0);
    chk("rst_data_count", bus.o_cmd_data_count, 1);
    rst = 1'b0;

    // Single read by req 2; later address change must not leak onto the command.
    set_req(2, 1'b0, 32'h10, 4'hF, 32'h0);
    @(negedge clk); issued[2]++;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin @(posedge clk); #3; hit = bus.i_req_en[2]; end
    chk("read_req_seen", hit, 1'b1);
    chk("read_cmd_en_early", bus.o_cmd_en, 0);
    @(posedge clk); #1;
    chk("read_cmd_en_1clk", bus.o_cmd_en, 1);
    chk("read_cmd_addr", bus.o_cmd_addr, 32'h10);
    chk("read_grant", bus.o_grant, 4'b0100);
    set_req(2, 1'b1, 32'h20, 4'h1, 32'h55);
    wait_ack("read_ack_seen", 40);
    chk("read_ack", bus.o_req_ack, 4'b0100);
    chk("read_data", bus.o_req_data, 32'hDEAD_BEEF);
    chk("read_error", bus.o_req_error, 0);
    wait_idle("read_idle", 40);

    // Contention from reset.
    @(negedge clk); rst = 1'b1;
    base = grant_log.size();
    set_req(0, 1'b0, 32'h100, 4'hF, 32'h0);
    set_req(1, 1'b1, 32'h104, 4'h3, 32'hA5A5_0001);
    set_req(3, 1'b0, 32'h10C, 4'hC, 32'h0);
    for (int k = 0; k < N; k++) done[k] = issued[k];
`ifdef AXI_CMD_ARB_FIXED_PRIORITY_EN
    issued[0] += 3; issued[3] += 3;
`else
    issued[0] += 2; issued[1] += 2; issued[3] += 2;
`endif
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 400 && grant_log.size() < base + 4; i++) @(negedge clk);
    chk("cont_grants_seen", grant_log.size() >= base + 4, 1'b1);
    if (grant_log.size() >= base + 4) begin
`ifdef AXI_CMD_ARB_FIXED_PRIORITY_EN
      chk("fixed_g0", grant_log[base], 0);
      chk("fixed_g1", grant_log[base+1], 0);
      chk("fixed_g2", grant_log[base+2], 0);
      chk("fixed_g3", grant_log[base+3], 3);
`else
      chk("rr_g0", grant_log[base], 0);
      chk("rr_g1", grant_log[base+1], 1);
      chk("rr_g2", grant_log[base+2], 3);
      chk("rr_g3", grant_log[base+3], 0);
`endif
    end
    for (int i = 0; i < 400 && (issued[0] > done[0] || issued[3] > done[3]); i++)
      @(negedge clk);
    wait_idle("cont_idle", 60);

    // Error pass-through on a write from req 1.
    set_req(1, 1'b1, 32'h44, 4'b0011, 32'h1234_5678);
    resp_err = 1'b1;
    issued[1]++;
    wait_ack("err_ack_seen", 40);
    chk("err_ack", bus.o_req_ack, 4'b0010);
    chk("err_flag", bus.o_req_error, 4'b0010);
    wait_idle("err_idle", 40);
    resp_err = 1'b0;

    // Early drop by req 0 one clock into the command.
    ack_dly = 4;
    set_req(0, 1'b0, 32'h80, 4'hF, 32'h0);
    issued[0]++;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin @(negedge clk); hit = bus.o_grant[0]; end
    chk("drop_granted", hit, 1'b1);
    hold[0] = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("drop_en_low", bus.i_req_en[0], 0);
    chk("drop_cmd_held", bus.o_cmd_en, 1);
    wait_ack("drop_ack_seen", 40);
    chk("drop_ack", bus.o_req_ack, 4'b0001);
    wait_idle("drop_idle", 40);
    hold[0] = 1'b0;

    // Reset while a command from req 2 is outstanding.
    ack_dly = 8;
    set_req(2, 1'b1, 32'hC0, 4'hF, 32'hCAFE_0002);
    issued[2]++;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin @(negedge clk); hit = bus.o_cmd_en; end
    chk("rstmid_cmd_en", hit, 1'b1);
    hold[2] = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rstmid_grant", bus.o_grant, 0);
    chk("rstmid_cmd_en0", bus.o_cmd_en, 0);
    chk("rstmid_cmd_addr", bus.o_cmd_addr, 0);
    chk("rstmid_ack", bus.o_req_ack, 0);
    chk("rstmid_data", bus.o_req_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ack_dly = 1;
    set_req(3, 1'b1, 32'h3C, 4'hF, 32'h0BAD_F00D);
    issued[3]++;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin @(negedge clk); hit = bus.o_cmd_en; end
    chk("after_rst_grant", bus.o_grant, 4'b1000);
    chk("after_rst_addr", bus.o_cmd_addr, 32'h3C);
    wait_ack("after_rst_ack_seen", 40);
    chk("after_rst_ack", bus.o_req_ack, 4'b1000);
    wait_idle("after_rst_idle", 40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
